// File: rtl/seg7_pkg.sv
// Shared widths, FSM encoding, display-set payload and hex segment patterns for the seg7 scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned HEX_W      = NUM_DIGITS * NIB_W;
  localparam int unsigned SEG7_W     = 7;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned CNT_W      = 8;

  localparam logic [NUM_DIGITS-1:0] AN_OFF  = '1;
  localparam logic [SEG_W-1:0]      SEG_OFF = '1;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [HEX_W-1:0]      hex;
    logic [NUM_DIGITS-1:0] dots;
    logic [NUM_DIGITS-1:0] blank;
  } disp_set_t;

  // Active-low {g,f,e,d,c,b,a} patterns; element n is the glyph for hex digit n.
  localparam logic [15:0][SEG7_W-1:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0]  hex_i,
  output logic [SEG7_W-1:0] seg_c_o
);

  assign seg_c_o = SEG_LUT[hex_i];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner: blanking gap between digits and
// double-buffered display data that only swaps at the frame boundary.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_src,
  input  logic                  load,
  input  logic [HEX_W-1:0]      hex_in,
  input  logic [NUM_DIGITS-1:0] dots_in,
  input  logic [NUM_DIGITS-1:0] blank_in,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  scan_q;
  disp_set_t             shadow_q, shadow_d;
  disp_set_t             active_q, active_d;
  logic                  pending_q, pending_d;
  logic                  frame_done_q, frame_done_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SEG_W-1:0]      seg_q, seg_d;

  logic                  scan_edge_c;
  logic                  wrap_c;
  disp_set_t             load_set_c;
  logic [NIB_W-1:0]      digit_hex_c;
  logic [SEG7_W-1:0]     digit_seg_c;

  assign scan_edge_c = scan_src & ~scan_q;
  assign wrap_c      = scan_edge_c && (idx_q == IDX_LAST);
  assign load_set_c  = {hex_in, dots_in, blank_in};
  assign digit_hex_c = active_q.hex[{idx_q, 2'b00} +: NIB_W];

  seg7_decode u_decode (
    .hex_i   (digit_hex_c),
    .seg_c_o (digit_seg_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_BLANK;
      idx_q        <= '0;
      cnt_q        <= '0;
      scan_q       <= 1'b0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      scan_q       <= scan_src;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  // Next state: blank timer, digit advance, shadow capture and frame-boundary commit
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    pending_d    = pending_q;
    frame_done_d = 1'b0;

    if (load) begin
      shadow_d  = load_set_c;
      pending_d = 1'b1;
    end

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRIVE: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // An edge always wins: it also restarts a blank interval already in progress
    if (scan_edge_c) begin
      idx_d   = idx_q + IDX_W'(1);
      cnt_d   = '0;
      state_d = ST_BLANK;
    end

    // A load landing on the wrap edge goes straight to the active set
    if (wrap_c) begin
      frame_done_d = 1'b1;
      if (load) begin
        active_d  = load_set_c;
        pending_d = 1'b0;
      end else if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  // Output decode; registered above so an/seg lag state/index by one cycle
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if ((state_q == ST_DRIVE) && !active_q.blank[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = {~active_q.dots[idx_q], digit_seg_c};
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
